bgm_streamer: RTL and testbench
===============================

Name: bgm_streamer

Overview:
Background-music sample pump. It sits downstream of the BGM sample ROM and directly feeds the audio codec's left/right Avalon-ST sinks. It prefetches samples from a synchronous ROM into a small FIFO and releases one sample per speed-dependent tick. Each channel completes a proper valid/ready handshake; samples are never emitted while the sink is not ready.

Parameters:
SAMPLE_W, 16, audio sample width
DEPTH, 47000, number of samples in ROM; address wraps after DEPTH-1
ADDR_W, 17, ROM address width (>= clog2(DEPTH))
FIFO_DEPTH, 4, prefetch FIFO entries (power of two)
DIV_W, 13, tick divider width
INTERVAL1, 6250, clocks per sample at speed 1
INTERVAL2, 5000, clocks per sample at speed 2
INTERVAL3, 4000, clocks per sample at speed 3

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
run  in  1  1 = divider advances (unpaused); 0 = paused
restart  in  1  single-cycle pulse; rewinds song to sample 0
speed  in  2  0 and 1 select INTERVAL1; 2 selects INTERVAL2; 3 selects INTERVAL3
rom_addr  out  ADDR_W  sample ROM read address
rom_data  in  SAMPLE_W  ROM data for the address registered one cycle earlier
l_ready  in  1  left sink ready
r_ready  in  1  right sink ready
l_valid  out  1  left sample valid
r_valid  out  1  right sample valid
left  out  SAMPLE_W  left sample
right  out  SAMPLE_W  right sample (always equals left)
underrun_cnt  out  8  saturating count of ticks that found the FIFO empty
overrun_cnt  out  8  saturating count of ticks that found a channel still pending

Behaviour:
- Reset clears all outputs, rom_addr, divider, FIFO and counters to 0. Fetch FSM goes to F_IDLE.
- Divider:
  - When run=1: if divider >= interval-1, divider <= 0 and tick=1 that cycle; otherwise divider increments.
  - When run=0: divider holds and no tick occurs.
  - A speed change takes effect on the next compare. If divider already exceeds the new interval-1, the tick fires on that cycle.
- Fetch FSM (one read in flight; independent of run):
  - F_IDLE -> F_WAIT when the FIFO is not full. rom_addr holds the next address.
  - F_WAIT -> F_IDLE, pushing rom_data into the FIFO.
  - Address increments with each push: DEPTH-1 -> 0.
- Output stage:
  - On tick with FIFO non-empty and neither channel pending: pop the FIFO into left/right, and set l_valid=r_valid=1 on the next edge.
  - Each valid clears independently on a cycle where valid & ready is true. left/right hold stable while either valid is high.
- Tick with FIFO empty: no pop, valids unchanged, underrun_cnt +1 (saturates at 255).
- Tick with either valid still high: no pop, the held sample is kept, overrun_cnt +1 (saturates).
- Push and pop in the same cycle are both performed; occupancy is unchanged.
- run=0 does not stop fetch and does not stop pending handshakes from completing.
- restart (and reset) have priority over everything else:
  - Clear FIFO, divider, valids and address to 0; the FSM goes to F_IDLE.
  - An in-flight F_WAIT read is discarded.
  - Counters are preserved on restart and cleared only by reset.
- Latency: with run=1 from the cycle after reset, the first tick occurs on cycle interval-1 and valid is high on cycle interval. The FIFO fills to FIFO_DEPTH within 2*FIFO_DEPTH cycles.

Decomposition:
- Package bgm_pkg: SAMPLE_W, interval defaults, and the typedef enum fetch_state_t {F_IDLE, F_WAIT}.
- Sub-module sync_fifo (parameters WIDTH, DEPTH):
  - Inputs: push, pop, clear.
  - Outputs: full, empty, count.
  - Pop-before-push ordering, so simultaneous push and pop are legal when full.

Test Plan:
1. Bench parameters INTERVAL1=8, DEPTH=6; ROM[i]=16'h1000+i; run=1 with ready tied high. Expected: valid pulses every 8 cycles, first at cycle 8; samples 1000,1001…1005 then 1000 again (wrap).
2. l_ready=1, r_ready=0 for 20 cycles (INTERVAL1=8). Expected: l_valid drops after 1 cycle; r_valid holds with right stable; overrun_cnt=2; the next sample is released only on the first tick after r_ready=1.
3. rom fetch stalled by holding restart high and releasing it 1 cycle before a tick. Expected: the tick finds the FIFO empty, underrun_cnt=1 and no valid; the next tick emits 16'h1000.
4. run=0 for 30 cycles mid-song. Expected: no valids; divider frozen; FIFO full (count=4); on run=1, the next valid appears after the remaining divider cycles.
5. speed switched 1->3 (INTERVAL3=4) while divider=6. Expected: tick on the next cycle, then every 4 cycles.
6. restart pulse while in F_WAIT at address 3 with l_valid pending. Expected: valids drop next cycle and rom_addr=0; the first sample after the next tick is 16'h1000; counters unchanged.

Source files
------------

// File: rtl/bgm_pkg.sv
// Shared types and default timing constants for the background-music sample pump.
package bgm_pkg;

    localparam int SAMPLE_W  = 16;
    localparam int INTERVAL1 = 6250;
    localparam int INTERVAL2 = 5000;
    localparam int INTERVAL3 = 4000;

    typedef enum logic {
        F_IDLE,
        F_WAIT
    } fetch_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with show-ahead read data; clear flushes contents in one cycle.
// Pop is evaluated before push, so a push into a full FIFO is accepted when a pop happens alongside.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == FULL_CNT);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !(reset || clear)) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/bgm_streamer.sv
// Background-music pump: prefetches ROM samples into a FIFO and releases one per divider tick
// to the left/right sinks, each completing its own valid/ready handshake.
module bgm_streamer #(
    parameter int SAMPLE_W   = bgm_pkg::SAMPLE_W,
    parameter int DEPTH      = 47000,
    parameter int ADDR_W     = 17,
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_W      = 13,
    parameter int INTERVAL1  = bgm_pkg::INTERVAL1,
    parameter int INTERVAL2  = bgm_pkg::INTERVAL2,
    parameter int INTERVAL3  = bgm_pkg::INTERVAL3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
    input  logic                restart,
    input  logic [1:0]          speed,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [SAMPLE_W-1:0] rom_data,
    input  logic                l_ready,
    input  logic                r_ready,
    output logic                l_valid,
    output logic                r_valid,
    output logic [SAMPLE_W-1:0] left,
    output logic [SAMPLE_W-1:0] right,
    output logic [7:0]          underrun_cnt,
    output logic [7:0]          overrun_cnt
);

    import bgm_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    fetch_state_t          state;
    logic [DIV_W-1:0]      div;
    logic [DIV_W-1:0]      limit;
    logic                  tick;
    logic                  pending;
    logic                  pop;
    logic                  push;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CW-1:0]         fifo_count;
    logic [SAMPLE_W-1:0]   fifo_head;
    logic [SAMPLE_W-1:0]   sample;

    always_comb begin
        limit = DIV_W'(INTERVAL1 - 1);
        case (speed)
            2'd2:    limit = DIV_W'(INTERVAL2 - 1);
            2'd3:    limit = DIV_W'(INTERVAL3 - 1);
            default: limit = DIV_W'(INTERVAL1 - 1);
        endcase
    end

    // >= rather than == so a speed-up past the current count fires immediately
    assign tick    = run && (div >= limit);
    assign pending = l_valid || r_valid;
    assign pop     = tick && !restart && !fifo_empty && !pending;
    assign push    = (state == F_WAIT);
    assign left    = sample;
    assign right   = sample;

    always_ff @(posedge clk) begin
        if (reset || restart) begin
            div <= '0;
        end else if (run) begin
            div <= tick ? '0 : div + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || restart) begin
            state    <= F_IDLE;
            rom_addr <= '0;
        end else begin
            case (state)
                F_IDLE: if (!fifo_full) state <= F_WAIT;
                F_WAIT: begin
                    state    <= F_IDLE;
                    rom_addr <= (rom_addr == LAST_ADDR) ? '0 : rom_addr + 1'b1;
                end
                default: state <= F_IDLE;
            endcase
        end
    end

    sync_fifo #(
        .WIDTH (SAMPLE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (restart),
        .push      (push),
        .push_data (rom_data),
        .pop       (pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            l_valid <= 1'b0;
            r_valid <= 1'b0;
            sample  <= '0;
        end else if (restart) begin
            l_valid <= 1'b0;
            r_valid <= 1'b0;
        end else if (pop) begin
            sample  <= fifo_head;
            l_valid <= 1'b1;
            r_valid <= 1'b1;
        end else begin
            if (l_valid && l_ready) l_valid <= 1'b0;
            if (r_valid && r_ready) r_valid <= 1'b0;
        end
    end

    // Counters survive restart; only reset clears them
    always_ff @(posedge clk) begin
        if (reset) begin
            underrun_cnt <= '0;
            overrun_cnt  <= '0;
        end else if (tick && !restart) begin
            if (fifo_empty && underrun_cnt != 8'hFF) underrun_cnt <= underrun_cnt + 1'b1;
            if (pending && overrun_cnt != 8'hFF)     overrun_cnt  <= overrun_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) assert (fifo_full == (fifo_count == CW'(FIFO_DEPTH)));
    end

endmodule

// File: tb/tb_bgm_streamer.sv
// Directed bench for bgm_streamer: steady streaming, backpressure, pause, speed change, restart, underrun.
module tb_bgm_streamer;

    import bgm_pkg::*;

    logic        clk;
    logic        reset;
    logic        run;
    logic        restart;
    logic [1:0]  speed;
    logic [16:0] rom_addr;
    logic [15:0] rom_data;
    logic        l_ready;
    logic        r_ready;
    logic        l_valid;
    logic        r_valid;
    logic [15:0] left;
    logic [15:0] right;
    logic [7:0]  underrun_cnt;
    logic [7:0]  overrun_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    bgm_streamer #(
        .SAMPLE_W   (16),
        .DEPTH      (6),
        .ADDR_W     (17),
        .FIFO_DEPTH (4),
        .DIV_W      (13),
        .INTERVAL1  (8),
        .INTERVAL2  (2),
        .INTERVAL3  (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .run          (run),
        .restart      (restart),
        .speed        (speed),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
        .l_ready      (l_ready),
        .r_ready      (r_ready),
        .l_valid      (l_valid),
        .r_valid      (r_valid),
        .left         (left),
        .right        (right),
        .underrun_cnt (underrun_cnt),
        .overrun_cnt  (overrun_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous ROM model: ROM[i] = 16'h1000 + i
    always @(posedge clk) rom_data <= 16'h1000 + 16'(rom_addr);

    typedef struct {
        int          cyc;
        logic        set_l;
        logic        set_r;
        logic        lv;
        logic        rv;
        logic [15:0] dat;
        logic [7:0]  ovr;
        logic [7:0]  und;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(int c, logic sl, logic sr, logic lv, logic rv,
                                logic [15:0] d, logic [7:0] o, logic [7:0] u);
        vec_t v;
        v.cyc = c; v.set_l = sl; v.set_r = sr; v.lv = lv; v.rv = rv;
        v.dat = d; v.ovr = o; v.und = u;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic goto(input int c);
        while (cyc < c) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    initial begin
        int seen;
        reset   = 1'b1;
        run     = 1'b0;
        restart = 1'b0;
        speed   = 2'd0;
        l_ready = 1'b1;
        r_ready = 1'b1;
        repeat (3) @(negedge clk);

        chk("reset l_valid", 32'(l_valid), 32'd0);
        chk("reset r_valid", 32'(r_valid), 32'd0);
        chk("reset left", 32'(left), 32'd0);
        chk("reset right", 32'(right), 32'd0);
        chk("reset rom_addr", 32'(rom_addr), 32'd0);
        chk("reset underrun", 32'(underrun_cnt), 32'd0);
        chk("reset overrun", 32'(overrun_cnt), 32'd0);

        // Streaming with wrap, then right-channel backpressure
        vecs.push_back(mk( 7, 1, 1, 0, 0, 16'h0000, 0, 0));
        vecs.push_back(mk( 8, 1, 1, 1, 1, 16'h1000, 0, 0));
        vecs.push_back(mk( 9, 1, 1, 0, 0, 16'h1000, 0, 0));
        vecs.push_back(mk(15, 1, 1, 0, 0, 16'h1000, 0, 0));
        vecs.push_back(mk(16, 1, 1, 1, 1, 16'h1001, 0, 0));
        vecs.push_back(mk(24, 1, 1, 1, 1, 16'h1002, 0, 0));
        vecs.push_back(mk(32, 1, 1, 1, 1, 16'h1003, 0, 0));
        vecs.push_back(mk(40, 1, 1, 1, 1, 16'h1004, 0, 0));
        vecs.push_back(mk(48, 1, 1, 1, 1, 16'h1005, 0, 0));
        vecs.push_back(mk(56, 1, 1, 1, 1, 16'h1000, 0, 0));
        vecs.push_back(mk(57, 1, 1, 0, 0, 16'h1000, 0, 0));
        vecs.push_back(mk(60, 1, 0, 0, 0, 16'h1000, 0, 0));
        vecs.push_back(mk(64, 1, 0, 1, 1, 16'h1001, 0, 0));
        vecs.push_back(mk(65, 1, 0, 0, 1, 16'h1001, 0, 0));
        vecs.push_back(mk(71, 1, 0, 0, 1, 16'h1001, 0, 0));
        vecs.push_back(mk(72, 1, 0, 0, 1, 16'h1001, 1, 0));
        vecs.push_back(mk(80, 1, 1, 0, 1, 16'h1001, 2, 0));
        vecs.push_back(mk(81, 1, 1, 0, 0, 16'h1001, 2, 0));
        vecs.push_back(mk(87, 1, 1, 0, 0, 16'h1001, 2, 0));
        vecs.push_back(mk(88, 1, 1, 1, 1, 16'h1002, 2, 0));

        reset = 1'b0;
        run   = 1'b1;
        cyc   = 0;

        foreach (vecs[i]) begin
            goto(vecs[i].cyc);
            chk($sformatf("vec%0d l_valid", i), 32'(l_valid), 32'(vecs[i].lv));
            chk($sformatf("vec%0d r_valid", i), 32'(r_valid), 32'(vecs[i].rv));
            chk($sformatf("vec%0d left", i), 32'(left), 32'(vecs[i].dat));
            chk($sformatf("vec%0d right", i), 32'(right), 32'(vecs[i].dat));
            chk($sformatf("vec%0d overrun", i), 32'(overrun_cnt), 32'(vecs[i].ovr));
            chk($sformatf("vec%0d underrun", i), 32'(underrun_cnt), 32'(vecs[i].und));
            l_ready = vecs[i].set_l;
            r_ready = vecs[i].set_r;
        end

        // Pause for 30 cycles: divider frozen, fetch keeps the FIFO full
        goto(90);
        chk("pause div start", 32'(dut.div), 32'd2);
        run = 1'b0;
        seen = 0;
        for (int k = 0; k < 30; k++) begin
            goto(cyc + 1);
            if (l_valid || r_valid) seen++;
        end
        chk("pause valids seen", 32'(seen), 32'd0);
        chk("pause div held", 32'(dut.div), 32'd2);
        chk("pause fifo count", 32'(dut.fifo_count), 32'd4);
        run = 1'b1;
        goto(125);
        chk("resume early valid", 32'(l_valid), 32'd0);
        goto(126);
        chk("resume valid", 32'(l_valid), 32'd1);
        chk("resume sample", 32'(left), 32'h1003);

        // Speed 1 -> 3 with divider already past the new limit
        goto(132);
        chk("speed div", 32'(dut.div), 32'd6);
        speed = 2'd3;
        chk("speed pre valid", 32'(l_valid), 32'd0);
        goto(133);
        chk("speed fast tick valid", 32'(l_valid), 32'd1);
        chk("speed fast tick sample", 32'(left), 32'h1004);
        goto(136);
        chk("speed gap valid", 32'(l_valid), 32'd0);
        goto(137);
        chk("speed 4cyc valid", 32'(l_valid), 32'd1);
        chk("speed 4cyc sample", 32'(left), 32'h1005);
        l_ready = 1'b0;

        // Restart while a read of address 3 is in flight and left is pending
        goto(138);
        chk("pre-restart l_valid", 32'(l_valid), 32'd1);
        chk("pre-restart r_valid", 32'(r_valid), 32'd0);
        chk("pre-restart rom_addr", 32'(rom_addr), 32'd3);
        chk("pre-restart F_WAIT", 32'(dut.state == F_WAIT), 32'd1);
        restart = 1'b1;
        goto(139);
        restart = 1'b0;
        l_ready = 1'b1;
        speed   = 2'd0;
        chk("restart l_valid", 32'(l_valid), 32'd0);
        chk("restart r_valid", 32'(r_valid), 32'd0);
        chk("restart rom_addr", 32'(rom_addr), 32'd0);
        chk("restart overrun kept", 32'(overrun_cnt), 32'd2);
        chk("restart underrun kept", 32'(underrun_cnt), 32'd0);
        goto(146);
        chk("post-restart early", 32'(l_valid), 32'd0);
        goto(147);
        chk("post-restart valid", 32'(l_valid), 32'd1);
        chk("post-restart sample", 32'(left), 32'h1000);

        // Hold restart to starve fetch, release one cycle before a tick
        goto(148);
        restart = 1'b1;
        speed   = 2'd2;
        goto(152);
        restart = 1'b0;
        chk("starve fifo count", 32'(dut.fifo_count), 32'd0);
        goto(153);
        chk("starve underrun before", 32'(underrun_cnt), 32'd0);
        goto(154);
        chk("starve underrun", 32'(underrun_cnt), 32'd1);
        chk("starve no valid", 32'(l_valid), 32'd0);
        goto(156);
        chk("starve next valid", 32'(l_valid), 32'd1);
        chk("starve next sample", 32'(left), 32'h1000);
        chk("starve overrun kept", 32'(overrun_cnt), 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
